regfile_writeback: RTL and testbench

- Write-back stage that drives the single write port of the integer register file.
- Merges results from two producers into one write per cycle:
  - ALU results, through a small FIFO.
  - Load data from the memory unit, which has priority.
- Keeps a per-register busy scoreboard so issue logic can stall on RAW hazards.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_writeback.sv | 176 +++++++++++++++++
 tb/tb_regfile_writeback.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: write-back stage driving the single integer register
// file write port. Load results have priority over ALU results. ALU results
// go through a small FIFO and bypass it when it is empty. A starvation
// counter forces the ALU FIFO head through after STARVE_LIMIT_P lost cycles.
// A per-register busy scoreboard tracks outstanding writes for RAW stalls.
// Optional feature macro: REGFILE_WRITEBACK_FORWARD_EN adds two forwarding
// read ports that cover the register file's one-cycle read/write gap.
module regfile_writeback #(
  parameter int DATA_WIDTH_P   = 32,
  parameter int ADDR_WIDTH_P   = 5,
  parameter int DEPTH_P        = 32,
  parameter int FIFO_DEPTH_P   = 2,
  parameter int STARVE_LIMIT_P = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_issue_valid,
  input  logic [ADDR_WIDTH_P-1:0] i_issue_addr,
  output logic [DEPTH_P-1:0]      o_busy,
  input  logic                    i_alu_valid,
  output logic                    o_alu_ready,
  input  logic [ADDR_WIDTH_P-1:0] i_alu_addr,
  input  logic [DATA_WIDTH_P-1:0] i_alu_data,
  input  logic                    i_mem_valid,
  output logic                    o_mem_ready,
  input  logic [ADDR_WIDTH_P-1:0] i_mem_addr,
  input  logic [DATA_WIDTH_P-1:0] i_mem_data,
`ifdef REGFILE_WRITEBACK_FORWARD_EN
  input  logic [ADDR_WIDTH_P-1:0] i_fwd_addr_a,
  input  logic [ADDR_WIDTH_P-1:0] i_fwd_addr_b,
  output logic                    o_fwd_hit_a,
  output logic                    o_fwd_hit_b,
  output logic [DATA_WIDTH_P-1:0] o_fwd_data_a,
  output logic [DATA_WIDTH_P-1:0] o_fwd_data_b,
`endif
  output logic                    o_wr_enable,
  output logic [ADDR_WIDTH_P-1:0] o_wr_addr,
  output logic [DATA_WIDTH_P-1:0] o_wr_data
);

  localparam int FIFO_AW  = $clog2(FIFO_DEPTH_P);
  localparam int CNT_W    = FIFO_AW + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT_P + 1);

  // FIFO storage and control
  logic [FIFO_DEPTH_P-1:0][ADDR_WIDTH_P-1:0] fifo_addr_q;
  logic [FIFO_DEPTH_P-1:0][DATA_WIDTH_P-1:0] fifo_data_q;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  // Output register and scoreboard
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH_P-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH_P-1:0] wr_data_q, wr_data_d;
  logic [DEPTH_P-1:0]      busy_q, busy_d;

  // Arbitration signals
  logic                    fifo_empty, fifo_full, force_alu;
  logic                    alu_acc, mem_win, alu_win, cand_valid;
  logic                    push, pop;
  logic [ADDR_WIDTH_P-1:0] cand_addr, win_addr;
  logic [DATA_WIDTH_P-1:0] cand_data, win_data;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH_P));
  assign force_alu  = (starve_q == STARVE_W'(STARVE_LIMIT_P));

  // Ready depends only on registered state
  assign o_alu_ready = ~fifo_full;
  assign o_mem_ready = ~force_alu;

  assign alu_acc = i_alu_valid & ~fifo_full;

  // Candidate is the FIFO head, or the incoming result when the FIFO is empty
  assign cand_valid = ~fifo_empty | alu_acc;
  assign cand_addr  = fifo_empty ? i_alu_addr : fifo_addr_q[rd_ptr_q];
  assign cand_data  = fifo_empty ? i_alu_data : fifo_data_q[rd_ptr_q];

  // A load can only win when it is not being held off by force_alu
  assign mem_win = i_mem_valid & ~force_alu;
  assign alu_win = cand_valid & ~mem_win;

  assign win_addr = mem_win ? i_mem_addr : cand_addr;
  assign win_data = mem_win ? i_mem_data : cand_data;

  // Fall-through winners are never stored
  assign pop  = alu_win & ~fifo_empty;
  assign push = alu_acc & ~(alu_win & fifo_empty);

  // FIFO pointer/count and starvation counter next state
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    starve_d = starve_q;
    if (fifo_empty || alu_win)  starve_d = '0;
    else if (!force_alu)        starve_d = starve_q + STARVE_W'(1);
  end

  // Output register next state; writes to r0 are consumed silently
  always_comb begin
    wr_en_d   = (mem_win | alu_win) && (win_addr != '0);
    wr_addr_d = wr_en_d ? win_addr : wr_addr_q;
    wr_data_d = wr_en_d ? win_data : wr_data_q;
  end

  // Scoreboard: clear on write, then set on issue so that set wins
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH_P; r++) begin
      if (wr_en_d && (win_addr == ADDR_WIDTH_P'(r)))
        busy_d[r] = 1'b0;
      if (i_issue_valid && (i_issue_addr != '0) && (i_issue_addr == ADDR_WIDTH_P'(r)))
        busy_d[r] = 1'b1;
    end
  end

  // FIFO control and starvation state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_addr_q <= '0;
      fifo_data_q <= '0;
    end else if (push) begin
      fifo_addr_q[wr_ptr_q] <= i_alu_addr;
      fifo_data_q[wr_ptr_q] <= i_alu_data;
    end
  end

  // Registered write port and scoreboard
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign o_wr_enable = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_busy      = busy_q;

`ifdef REGFILE_WRITEBACK_FORWARD_EN
  // Forward the in-flight write to readers that would otherwise see stale data
  assign o_fwd_hit_a  = wr_en_q && (wr_addr_q == i_fwd_addr_a) && (i_fwd_addr_a != '0);
  assign o_fwd_hit_b  = wr_en_q && (wr_addr_q == i_fwd_addr_b) && (i_fwd_addr_b != '0);
  assign o_fwd_data_a = wr_data_q;
  assign o_fwd_data_b = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a write-back scoreboard.
module tb_regfile_writeback;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_issue_valid = 1'b0;
  logic [AW-1:0] i_issue_addr = '0;
  logic [DP-1:0] o_busy;
  logic          i_alu_valid = 1'b0;
  logic          o_alu_ready;
  logic [AW-1:0] i_alu_addr = '0;
  logic [DW-1:0] i_alu_data = '0;
  logic          i_mem_valid = 1'b0;
  logic          o_mem_ready;
  logic [AW-1:0] i_mem_addr = '0;
  logic [DW-1:0] i_mem_data = '0;
  logic          o_wr_enable;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
`ifdef REGFILE_WRITEBACK_FORWARD_EN
  logic [AW-1:0] i_fwd_addr_a = '0;
  logic [AW-1:0] i_fwd_addr_b = '0;
  logic          o_fwd_hit_a, o_fwd_hit_b;
  logic [DW-1:0] o_fwd_data_a, o_fwd_data_b;
`endif

  regfile_writeback dut (
    .clk(clk), .reset(reset),
    .i_issue_valid(i_issue_valid), .i_issue_addr(i_issue_addr), .o_busy(o_busy),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
    .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
    .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
    .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
`ifdef REGFILE_WRITEBACK_FORWARD_EN
    .i_fwd_addr_a(i_fwd_addr_a), .i_fwd_addr_b(i_fwd_addr_b),
    .o_fwd_hit_a(o_fwd_hit_a), .o_fwd_hit_b(o_fwd_hit_b),
    .o_fwd_data_a(o_fwd_data_a), .o_fwd_data_b(o_fwd_data_b),
`endif
    .o_wr_enable(o_wr_enable), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [AW+DW-1:0] aq[$];
  logic [AW+DW-1:0] mq[$];
  logic mem_rdy_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (check writes, record accepts), then step
  // past the rising edge and retire accepted requests.
  task automatic tick();
    logic alu_acc, mem_acc;
    logic [AW+DW-1:0] got;
    @(negedge clk);
    alu_acc      = i_alu_valid && o_alu_ready;
    mem_acc      = i_mem_valid && o_mem_ready;
    mem_rdy_seen = o_mem_ready;
    if (o_wr_enable) begin
      got = {o_wr_addr, o_wr_data};
      if (aq.size() == 0 && mq.size() == 0)
        chk("wb_spurious", 64'(o_wr_enable), 64'(0));
      else if (aq.size() > 0 && aq[0] === got) begin
        chk("wb_alu", 64'(got), 64'(aq[0])); void'(aq.pop_front());
      end else if (mq.size() > 0) begin
        chk("wb_mem", 64'(got), 64'(mq[0])); void'(mq.pop_front());
      end else begin
        chk("wb_alu", 64'(got), 64'(aq[0])); void'(aq.pop_front());
      end
    end
    if (alu_acc && i_alu_addr != '0) aq.push_back({i_alu_addr, i_alu_data});
    if (mem_acc && i_mem_addr != '0) mq.push_back({i_mem_addr, i_mem_data});
    @(posedge clk);
    #1;
    if (alu_acc) i_alu_valid = 1'b0;
    if (mem_acc) i_mem_valid = 1'b0;
    i_issue_valid = 1'b0;
  endtask

  int lows;
  int lowidx;

  initial begin
    // Reset state
    #12;
    chk("rst_wr_en", 64'(o_wr_enable), 64'(0));
    chk("rst_wr_addr", 64'(o_wr_addr), 64'(0));
    chk("rst_wr_data", 64'(o_wr_data), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    @(posedge clk); #1 reset = 1'b1;
    chk("rst_alu_ready", 64'(o_alu_ready), 64'(1));
    chk("rst_mem_ready", 64'(o_mem_ready), 64'(1));

    // Fill the FIFO behind loads, then reset mid-transfer
    i_mem_valid = 1; i_mem_addr = 9; i_mem_data = 32'h100;
    i_alu_valid = 1; i_alu_addr = 1; i_alu_data = 32'h1;
    tick();
    i_mem_valid = 1; i_mem_addr = 9; i_mem_data = 32'h101;
    i_alu_valid = 1; i_alu_addr = 2; i_alu_data = 32'h2;
    tick();
    chk("fifo_full_ready", 64'(o_alu_ready), 64'(0));
    reset = 1'b0; i_alu_valid = 0; i_mem_valid = 0;
    #1;
    chk("midrst_wr_en", 64'(o_wr_enable), 64'(0));
    chk("midrst_busy", 64'(o_busy), 64'(0));
    aq.delete(); mq.delete();
    @(posedge clk); #1 reset = 1'b1;
    chk("midrst_alu_ready", 64'(o_alu_ready), 64'(1));
    chk("midrst_mem_ready", 64'(o_mem_ready), 64'(1));
    repeat (4) tick();
    chk("midrst_no_stale", 64'(o_wr_enable), 64'(0));

    // Single ALU result through an empty FIFO: one-cycle latency
    i_alu_valid = 1; i_alu_addr = 5; i_alu_data = 32'hDEADBEEF;
    chk("alu_pre_wr_en", 64'(o_wr_enable), 64'(0));
    tick();
    chk("alu_wr_en", 64'(o_wr_enable), 64'(1));
    chk("alu_wr_addr", 64'(o_wr_addr), 64'(5));
    chk("alu_wr_data", 64'(o_wr_data), 64'hDEADBEEF);
`ifdef REGFILE_WRITEBACK_FORWARD_EN
    i_fwd_addr_a = 5; i_fwd_addr_b = 6; #1;
    chk("fwd_hit_a", 64'(o_fwd_hit_a), 64'(1));
    chk("fwd_data_a", 64'(o_fwd_data_a), 64'hDEADBEEF);
    chk("fwd_hit_b", 64'(o_fwd_hit_b), 64'(0));
`endif
    tick();
    chk("idle_wr_en", 64'(o_wr_enable), 64'(0));
    chk("idle_hold_addr", 64'(o_wr_addr), 64'(5));

    // Load beats ALU in the same cycle; ALU follows next cycle
    i_alu_valid = 1; i_alu_addr = 3; i_alu_data = 32'h11;
    i_mem_valid = 1; i_mem_addr = 4; i_mem_data = 32'h22;
    tick();
    chk("prio_mem_addr", 64'(o_wr_addr), 64'(4));
    chk("prio_mem_data", 64'(o_wr_data), 64'h22);
    chk("prio_alu_ready", 64'(o_alu_ready), 64'(1));
    tick();
    chk("prio_alu_en", 64'(o_wr_enable), 64'(1));
    chk("prio_alu_addr", 64'(o_wr_addr), 64'(3));
    chk("prio_alu_data", 64'(o_wr_data), 64'h11);
    tick();

    // Continuous loads starve one ALU entry until force_alu
    lows = 0; lowidx = -1;
    for (int k = 0; k < 10; k++) begin
      if (!i_mem_valid) begin
        i_mem_valid = 1; i_mem_addr = 9; i_mem_data = 32'h200 + k;
      end
      if (k == 0) begin
        i_alu_valid = 1; i_alu_addr = 6; i_alu_data = 32'h66;
      end
      tick();
      if (!mem_rdy_seen) begin lows++; lowidx = k; end
    end
    i_mem_valid = 0;
    repeat (3) tick();
    chk("starve_low_cycles", 64'(lows), 64'(1));
    chk("starve_low_index", 64'(lowidx), 64'(5));
    chk("starve_alu_written", 64'(aq.size()), 64'(0));

    // Scoreboard set/clear
    i_issue_valid = 1; i_issue_addr = 7;
    tick();
    chk("busy_set", 64'(o_busy), 64'h80);
    repeat (2) tick();
    chk("busy_hold", 64'(o_busy), 64'h80);
    i_alu_valid = 1; i_alu_addr = 7; i_alu_data = 32'h77;
    tick();
    chk("busy_clr_wr", 64'(o_wr_enable), 64'(1));
    chk("busy_clr", 64'(o_busy), 64'(0));
    i_issue_valid = 1; i_issue_addr = 7;
    tick();
    chk("busy_reset", 64'(o_busy), 64'h80);
    i_alu_valid = 1; i_alu_addr = 7; i_alu_data = 32'h78;
    i_issue_valid = 1; i_issue_addr = 7;
    tick();
    chk("set_wins_wr", 64'(o_wr_enable), 64'(1));
    chk("set_wins_busy", 64'(o_busy), 64'h80);
    i_alu_valid = 1; i_alu_addr = 7; i_alu_data = 32'h79;
    tick();
    chk("busy_final_clr", 64'(o_busy), 64'(0));

    // Register 0: issue never marks busy, write is consumed silently
    i_issue_valid = 1; i_issue_addr = 0;
    tick();
    chk("r0_issue_busy", 64'(o_busy), 64'(0));
    i_alu_valid = 1; i_alu_addr = 0; i_alu_data = 32'hFF;
    chk("r0_alu_ready", 64'(o_alu_ready), 64'(1));
    tick();
    chk("r0_consumed", 64'(i_alu_valid), 64'(0));
    chk("r0_wr_en", 64'(o_wr_enable), 64'(0));
    chk("r0_busy", 64'(o_busy), 64'(0));
    chk("r0_hold_addr", 64'(o_wr_addr), 64'(7));
`ifdef REGFILE_WRITEBACK_FORWARD_EN
    i_fwd_addr_a = 0; #1;
    chk("r0_fwd_hit_a", 64'(o_fwd_hit_a), 64'(0));
`endif
    repeat (3) tick();
    chk("drain", 64'(aq.size() + mq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
